readout_scheduler: RTL and testbench
====================================

# readout_scheduler

Sequencer that drives the `read_out` command and transmit inputs. It round-robins over the B FIFO units and drains one non-empty unit into the readout RAM. It then points the RAM read address at the words just written and triggers one Ethernet packet carrying them. When all units stay empty, it sends a heartbeat packet periodically.

## Interface
- `B`, 24: number of FIFO units, 1..31.
- `WORDS`, 5: RAM words written per FIFO read.
- `FIFO_WAIT`, 340: cycles from the FIFO-read command to the RAM-address command. Must be ≥ 321 plus margin.
- `PKT_WAIT`, 184: cycles from the transmit toggle to eligibility for the next command. Must be ≥ packet length (46 ROM ops × 4).
- `HEARTBEAT`, 1000000: idle cycles before an empty packet is forced.

- `clk`, in, 1: clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `enable`, in, 1: scheduler runs when 1. When 0, no new sequence starts; a sequence in progress completes.
- `fifo_empty`, in, [B:1]: per-unit empty flags.
- `command`, out, 20: operand presented to `read_out`.
- `opcode`, out, 3: 5 = FIFO read, 6 = RAM read address.
- `strobe`, out, 1: toggle; each edge issues one command.
- `tx_strobe`, out, 1: toggle; each edge releases one packet.
- `seqnum`, out, 8: packet sequence number.
- `busy`, out, 1: 1 in every state except IDLE.

## Operation
- States: IDLE, FIFO_CMD, FIFO_HOLD, ADDR_CMD, SEND, PKT_HOLD.
- **IDLE.** Taken when `enable` is 1 and any `fifo_empty` bit is 0.
  - Selects the first non-empty unit, searching upward from `last+1`, wrapping B→1.
  - Loads `unit` and goes to FIFO_CMD.
  - The `fifo_empty` sample on the decision cycle is authoritative.
- **Heartbeat.** `hb_cnt` counts IDLE cycles while `enable` is 1.
  - At HEARTBEAT−1 with all units empty, IDLE goes to ADDR_CMD with `heartbeat`=1. No FIFO read is issued and `raddr` is unchanged.
  - `hb_cnt` clears on leaving IDLE and whenever `enable` is 0.
- **FIFO_CMD**, one cycle.
  - Sets `opcode`=5 and `command`={15'b0, unit[4:0]}.
  - Toggles `strobe`.
  - Loads `wait_cnt`=FIFO_WAIT−1 and goes to FIFO_HOLD.
- **FIFO_HOLD.** Decrements `wait_cnt`; at 0 goes to ADDR_CMD.
- **ADDR_CMD**, one cycle.
  - Sets `opcode`=6 and `command`={10'b0, raddr}.
  - Toggles `strobe`.
  - If not `heartbeat`: `raddr` ← (`raddr`+WORDS) mod 1024. This is 10-bit wrap arithmetic and matches the `read_out` write pointer.
  - Goes to SEND.
- **SEND**, one cycle.
  - Toggles `tx_strobe` and increments `seqnum` mod 256.
  - Loads `wait_cnt`=PKT_WAIT−1 and goes to PKT_HOLD.
  - If not `heartbeat`: `last` ← `unit`.
- **PKT_HOLD.** Decrements `wait_cnt`; at 0 clears `heartbeat` and goes to IDLE.
- **Command hold.** `command` and `opcode` keep their values until the next command cycle. No command is issued while a FIFO read could be in progress, so `read_out` never drops a command.
- **Reset values.**
  - State IDLE; `command`=0; `opcode`=0.
  - `strobe`=0; `tx_strobe`=0; `seqnum`=0.
  - `raddr`=0; `last`=B, so the first search starts at unit 1.
  - `heartbeat`=0; counters 0; `busy`=0.
- **Reset mid-sequence.** Everything returns to reset values immediately. The `read_out` pointers then diverge, and the whole design must be reset together.

## Timing
- All outputs are registered.
- `strobe` toggles in the same cycle `command`/`opcode` change. The values are stable for ≥ FIFO_WAIT or PKT_WAIT cycles afterwards.
- IDLE decision to `strobe` edge (FIFO read): 1 cycle.
- FIFO-read edge to RAM-address edge: FIFO_WAIT+1 cycles.
- RAM-address edge to `tx_strobe` edge: 1 cycle.
- `tx_strobe` edge to return to IDLE: PKT_WAIT cycles.
- Full data sequence: FIFO_WAIT+PKT_WAIT+3 cycles = 527 at defaults.
- `enable` falling during any non-IDLE state has no effect until IDLE.

## Structure
- Shared package `terpine_pkg`:
  - opcode constants `OP_FIFO_READ`=5 and `OP_RAM_READ`=6;
  - the RAM depth of 1024;
  - WORDS;
  - the state enum.
- One sub-module, `rr_pick`: combinational round-robin first-set search over [B:1] from `last+1`. Outputs `found` and `unit`.

## Test plan
- Reset, then clear `fifo_empty[3]` only:
  - `strobe` toggles with opcode 5, command 3;
  - 341 cycles later, opcode 6, command 0;
  - next cycle `tx_strobe` toggles and `seqnum`=1.
- Units 2, 5 and 24 non-empty continuously: served in order 2, 5, 24, 2, and the RAM addresses sent are 0, 5, 10, 15.
- 205 consecutive data sequences: the RAM address sent in the last is 1020, then `raddr` wraps to 1. Check (k·5) mod 1024 throughout.
- All units empty, HEARTBEAT=50:
  - no opcode-5 command is issued;
  - at idle cycle 50, opcode 6 with the unchanged `raddr`, then a `tx_strobe` toggle;
  - `seqnum` increments and `raddr` does not.
- `enable` dropped during FIFO_HOLD: the current sequence completes, including the packet; no further strobes are issued while `enable`=0.
- `rst_n` asserted mid-PKT_HOLD: all outputs are at reset values in the same cycle, and `busy`=0.

Source files
------------

// File: rtl/terpine_pkg.sv
// Shared constants and types for the readout sequencer: read_out opcodes,
// readout RAM geometry and the scheduler state encoding.
package terpine_pkg;
    localparam logic [2:0] OP_FIFO_READ = 3'd5;
    localparam logic [2:0] OP_RAM_READ  = 3'd6;
    localparam int         RAM_DEPTH    = 1024;
    localparam int         RAM_AW       = $clog2(RAM_DEPTH);
    localparam int         WORDS        = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FIFO_CMD,
        ST_FIFO_HOLD,
        ST_ADDR_CMD,
        ST_SEND,
        ST_PKT_HOLD
    } sched_state_t;

    // Addresses wrap at the RAM depth, which keeps them aligned with the read_out write pointer.
    function automatic logic [RAM_AW-1:0] raddr_advance(input logic [RAM_AW-1:0] addr,
                                                        input int unsigned       words);
        return addr + RAM_AW'(words);
    endfunction
endpackage

// File: rtl/readout_scheduler_if.sv
// Bus between the readout scheduler and the read_out / transmit logic.
// Handshake: strobe and tx_strobe are toggles. Every edge in either direction issues exactly one
// command (strobe) or releases exactly one packet (tx_strobe). command/opcode are valid from their
// strobe edge until the next one. There is no ready signal: the scheduler spaces edges far enough
// apart that the consumer always accepts them.
interface readout_scheduler_if #(parameter int B = 24);
    logic                      enable;
    logic [B:1]                fifo_empty;
    logic [19:0]               command;
    logic [2:0]                opcode;
    logic                      strobe;
    logic                      tx_strobe;
    logic [7:0]                seqnum;
    logic                      busy;
    terpine_pkg::sched_state_t state;

    modport master (input  enable, fifo_empty,
                    output command, opcode, strobe, tx_strobe, seqnum, busy, state);
    modport slave  (output enable, fifo_empty,
                    input  command, opcode, strobe, tx_strobe, seqnum, busy, state);
endinterface

// File: rtl/readout_scheduler_rr_pick.sv
// Round-robin first-set search over units [B:1], starting at last+1 and wrapping B -> 1.
// Purely combinational; o_found is low when no unit is requesting.
module rr_pick #(
    parameter int B = 24
) (
    input  logic [B:1] i_req,
    input  logic [4:0] i_last,
    output logic       o_found,
    output logic [4:0] o_unit
);
    logic [2*B-1:0] w_req2;
    logic [B-1:0]   w_rot;
    logic [5:0]     w_off;
    logic [5:0]     w_sum;

    // Bit j of w_rot is unit last+1+j; doubling the vector turns the B -> 1 wrap into a plain shift.
    assign w_req2 = {i_req, i_req};
    assign w_rot  = B'(w_req2 >> i_last);

    always_comb begin
        o_found = 1'b0;
        w_off   = 6'd0;
        for (int j = B - 1; j >= 0; j--) begin
            if (w_rot[j]) begin
                o_found = 1'b1;
                w_off   = 6'(j);
            end
        end
        w_sum  = 6'(i_last) + w_off + 6'd1;
        o_unit = (w_sum > 6'(B)) ? 5'(w_sum - 6'(B)) : 5'(w_sum);
    end
endmodule

// File: rtl/readout_scheduler.sv
// Readout scheduler: drains one non-empty FIFO unit into the readout RAM, points the RAM read
// address at the new words and releases one packet; sends a heartbeat packet when idle too long.
module readout_scheduler #(
    parameter int B         = 24,
    parameter int WORDS     = terpine_pkg::WORDS,
    parameter int FIFO_WAIT = 340,
    parameter int PKT_WAIT  = 184,
    parameter int HEARTBEAT = 1000000
) (
    input logic                 clk,
    input logic                 rst_n,
    readout_scheduler_if.master bus
);
    import terpine_pkg::*;

    localparam int WAIT_MAX = (FIFO_WAIT > PKT_WAIT) ? FIFO_WAIT : PKT_WAIT;
    localparam int WAIT_W   = $clog2(WAIT_MAX + 1);
    localparam int HB_W     = $clog2(HEARTBEAT + 1);

    sched_state_t      r_state;
    logic [4:0]        r_unit;
    logic [4:0]        r_last;
    logic [RAM_AW-1:0] r_raddr;
    logic [WAIT_W-1:0] r_wait;
    logic [HB_W-1:0]   r_hb;
    logic              r_heartbeat;
    logic [19:0]       r_command;
    logic [2:0]        r_opcode;
    logic              r_strobe;
    logic              r_tx_strobe;
    logic [7:0]        r_seqnum;
    logic              r_busy;

    logic [B:1]        w_req;
    logic              w_found;
    logic [4:0]        w_unit;

    assign w_req = ~bus.fifo_empty;

    rr_pick #(.B(B)) u_rr_pick (
        .i_req   (w_req),
        .i_last  (r_last),
        .o_found (w_found),
        .o_unit  (w_unit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_unit      <= 5'd0;
            r_last      <= 5'(B);
            r_raddr     <= '0;
            r_wait      <= '0;
            r_hb        <= '0;
            r_heartbeat <= 1'b0;
            r_command   <= 20'd0;
            r_opcode    <= 3'd0;
            r_strobe    <= 1'b0;
            r_tx_strobe <= 1'b0;
            r_seqnum    <= 8'd0;
            r_busy      <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.enable && w_found) begin
                        r_unit  <= w_unit;
                        r_hb    <= '0;
                        r_busy  <= 1'b1;
                        r_state <= ST_FIFO_CMD;
                    end else if (bus.enable && (r_hb == HB_W'(HEARTBEAT - 1))) begin
                        // Nothing to drain for too long: send an empty packet at the current address.
                        r_heartbeat <= 1'b1;
                        r_hb        <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= ST_ADDR_CMD;
                    end else if (bus.enable) begin
                        r_hb <= r_hb + HB_W'(1);
                    end else begin
                        r_hb <= '0;
                    end
                end
                ST_FIFO_CMD: begin
                    r_opcode  <= OP_FIFO_READ;
                    r_command <= {15'b0, r_unit};
                    r_strobe  <= ~r_strobe;
                    r_wait    <= WAIT_W'(FIFO_WAIT - 1);
                    r_state   <= ST_FIFO_HOLD;
                end
                ST_FIFO_HOLD: begin
                    if (r_wait == '0) begin
                        r_state <= ST_ADDR_CMD;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                ST_ADDR_CMD: begin
                    r_opcode  <= OP_RAM_READ;
                    r_command <= {10'b0, r_raddr};
                    r_strobe  <= ~r_strobe;
                    if (!r_heartbeat) begin
                        r_raddr <= raddr_advance(r_raddr, WORDS);
                    end
                    r_state   <= ST_SEND;
                end
                ST_SEND: begin
                    r_tx_strobe <= ~r_tx_strobe;
                    r_seqnum    <= r_seqnum + 8'd1;
                    r_wait      <= WAIT_W'(PKT_WAIT - 1);
                    if (!r_heartbeat) begin
                        r_last <= r_unit;
                    end
                    r_state     <= ST_PKT_HOLD;
                end
                ST_PKT_HOLD: begin
                    if (r_wait == '0) begin
                        r_heartbeat <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end else begin
                        r_wait <= r_wait - WAIT_W'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.command   = r_command;
    assign bus.opcode    = r_opcode;
    assign bus.strobe    = r_strobe;
    assign bus.tx_strobe = r_tx_strobe;
    assign bus.seqnum    = r_seqnum;
    assign bus.busy      = r_busy;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_readout_scheduler.sv
// Bench for readout_scheduler: randomized inputs against a transaction-level timing model,
// plus directed scenarios checked from the observed strobe/packet logs.
module tb_readout_scheduler;
    import terpine_pkg::*;

    localparam int B   = 24;
    localparam int FW  = 40;
    localparam int PW  = 24;
    localparam int HB  = 50;
    localparam int SEQ = FW + PW + 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    readout_scheduler_if #(.B(B)) bus();

    readout_scheduler #(.B(B), .WORDS(WORDS), .FIFO_WAIT(FW), .PKT_WAIT(PW), .HEARTBEAT(HB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model: when each edge must appear and what it carries
    typedef struct packed {
        int unsigned cyc;
        logic        is_tx;
        logic [2:0]  op;
        logic [19:0] data;
    } ev_t;
    ev_t exp_q[$];

    int         cyc = 0;
    int         m_free, m_busy_until, m_idle_run, m_data_cnt, m_last;
    logic [7:0] m_seq;
    int         pick, u;

    function automatic ev_t mk_ev(input int c, input logic tx, input logic [2:0] op, input int d);
        ev_t e;
        e.cyc = c; e.is_tx = tx; e.op = op; e.data = 20'(d);
        return e;
    endfunction

    always @(posedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            m_free = 0; m_busy_until = -1; m_idle_run = 0; m_data_cnt = 0; m_last = B; m_seq = 8'd0;
        end else if (cyc >= m_free) begin
            pick = 0;
            if (bus.enable)
                for (int k = 1; k <= B && pick == 0; k++) begin
                    u = ((m_last - 1 + k) % B) + 1;
                    if (!bus.fifo_empty[u]) pick = u;
                end
            if (pick != 0) begin
                m_seq = m_seq + 8'd1;
                exp_q.push_back(mk_ev(cyc + 1, 1'b0, OP_FIFO_READ, pick));
                exp_q.push_back(mk_ev(cyc + FW + 2, 1'b0, OP_RAM_READ, (m_data_cnt * WORDS) % RAM_DEPTH));
                exp_q.push_back(mk_ev(cyc + FW + 3, 1'b1, 3'd0, int'(m_seq)));
                m_data_cnt++; m_last = pick; m_idle_run = 0;
                m_free = cyc + FW + PW + 4; m_busy_until = cyc + FW + PW + 2;
            end else if (bus.enable) begin
                m_idle_run++;
                if (m_idle_run == HB) begin
                    m_seq = m_seq + 8'd1;
                    exp_q.push_back(mk_ev(cyc + 1, 1'b0, OP_RAM_READ, (m_data_cnt * WORDS) % RAM_DEPTH));
                    exp_q.push_back(mk_ev(cyc + 2, 1'b1, 3'd0, int'(m_seq)));
                    m_idle_run = 0;
                    m_free = cyc + PW + 3; m_busy_until = cyc + PW + 1;
                end
            end else begin
                m_idle_run = 0;
            end
        end
    end

    // ---------------- monitor / scoreboard (samples on the falling edge)
    typedef struct { int cyc; int op; int cmd; } sl_t;
    typedef struct { int cyc; int seq; } tl_t;
    sl_t strobe_log[$];
    tl_t tx_log[$];

    logic        prev_strobe, prev_tx;
    logic [2:0]  cur_op;
    logic [19:0] cur_cmd;
    logic [7:0]  cur_seq;
    ev_t         e;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe = 1'b0; prev_tx = 1'b0; cur_op = 3'd0; cur_cmd = 20'd0; cur_seq = 8'd0;
        end else begin
            if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                chk("missed_edge_cycle", cyc, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if (bus.strobe != prev_strobe || bus.tx_strobe != prev_tx) begin
                if (bus.strobe != prev_strobe)
                    strobe_log.push_back('{cyc, int'(bus.opcode), int'(bus.command)});
                else
                    tx_log.push_back('{cyc, int'(bus.seqnum)});
                if (exp_q.size() == 0) begin
                    chk("unexpected_edge", {bus.strobe != prev_strobe, bus.tx_strobe != prev_tx}, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("edge_cycle", cyc, e.cyc);
                    chk("edge_is_tx", bus.tx_strobe != prev_tx, e.is_tx);
                    if (e.is_tx) cur_seq = e.data[7:0];
                    else begin cur_op = e.op; cur_cmd = e.data; end
                end
            end
            chk("opcode", bus.opcode, cur_op);
            chk("command", bus.command, cur_cmd);
            chk("seqnum", bus.seqnum, cur_seq);
            chk("busy", bus.busy, cyc <= m_busy_until);
            prev_strobe = bus.strobe;
            prev_tx     = bus.tx_strobe;
        end
    end

    // ---------------- driver tasks
    int rel_cyc;

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [B:1] fe, input logic en);
        step();
        rst_n = 1'b0; bus.fifo_empty = fe; bus.enable = en;
        repeat (2) step();
        chk("rst_state", bus.state, ST_IDLE);
        chk("rst_busy", bus.busy, 0);
        chk("rst_outputs", {bus.strobe, bus.tx_strobe, bus.opcode, bus.command, bus.seqnum}, 0);
        rst_n = 1'b1;
        rel_cyc = cyc + 1;
        strobe_log.delete();
        tx_log.delete();
    endtask

    task automatic wait_tx(input int n, input int budget, input string tag);
        int t = 0;
        while (tx_log.size() < n && t < budget) begin step(); t++; end
        chk(tag, tx_log.size(), n);
    endtask

    task automatic wait_strobe(input int n, input int budget, input string tag);
        int t = 0;
        while (strobe_log.size() < n && t < budget) begin step(); t++; end
        chk(tag, strobe_log.size(), n);
    endtask

    function automatic int nth_idx(input int op, input int k);
        int n = 0;
        foreach (strobe_log[i])
            if (strobe_log[i].op == op) begin
                if (n == k) return i;
                n++;
            end
        return -1;
    endfunction

    function automatic int count_op(input int op);
        int n = 0;
        foreach (strobe_log[i]) if (strobe_log[i].op == op) n++;
        return n;
    endfunction

    function automatic logic [B:1] only_set(input int unit_a, input int unit_b, input int unit_c);
        logic [B:1] fe = '1;
        if (unit_a > 0) fe[unit_a] = 1'b0;
        if (unit_b > 0) fe[unit_b] = 1'b0;
        if (unit_c > 0) fe[unit_c] = 1'b0;
        return fe;
    endfunction

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    // ---------------- test sequence
    initial begin
        int exp_units[4] = '{2, 5, 24, 2};
        int exp_addrs[4] = '{0, 5, 10, 15};
        int i5, i6;
        logic [B:1] fe;

        bus.enable = 1'b0;
        bus.fifo_empty = '1;

        // single unit 3: command timing and first packet
        do_reset(only_set(3, 0, 0), 1'b1);
        wait_tx(1, SEQ + 10, "t1_tx_seen");
        bus.fifo_empty = '1;
        chk("t1_fifo_op", strobe_log[0].op, OP_FIFO_READ);
        chk("t1_fifo_cmd", strobe_log[0].cmd, 3);
        chk("t1_decision_to_edge", strobe_log[0].cyc - rel_cyc, 1);
        chk("t1_addr_op", strobe_log[1].op, OP_RAM_READ);
        chk("t1_addr_cmd", strobe_log[1].cmd, 0);
        chk("t1_fifo_to_addr", strobe_log[1].cyc - strobe_log[0].cyc, FW + 1);
        chk("t1_addr_to_tx", tx_log[0].cyc - strobe_log[1].cyc, 1);
        chk("t1_seqnum", tx_log[0].seq, 1);

        // units 2, 5, 24 always pending: round-robin order and address advance
        do_reset(only_set(2, 5, 24), 1'b1);
        wait_tx(4, 4 * SEQ + 10, "t2_tx_seen");
        for (int k = 0; k < 4; k++) begin
            i5 = nth_idx(OP_FIFO_READ, k);
            i6 = nth_idx(OP_RAM_READ, k);
            chk("t2_unit_order", (i5 < 0) ? -1 : strobe_log[i5].cmd, exp_units[k]);
            chk("t2_raddr", (i6 < 0) ? -1 : strobe_log[i6].cmd, exp_addrs[k]);
        end

        // 206 back-to-back data sequences with shifting requests: RAM address wrap
        do_reset(only_set(7, 0, 0), 1'b1);
        for (int t = 0; t < 206 * SEQ + 50 && tx_log.size() < 206; t++) begin
            step();
            if ($urandom_range(0, 9) == 0) begin
                fe = B'($urandom);
                fe[$urandom_range(1, B)] = 1'b0;
                bus.fifo_empty = fe;
            end
        end
        chk("t3_tx_count", tx_log.size(), 206);
        for (int k = 0; k < 206; k++) begin
            i6 = nth_idx(OP_RAM_READ, k);
            chk("t3_addr_k", (i6 < 0) ? -1 : strobe_log[i6].cmd, (k * WORDS) % RAM_DEPTH);
        end
        i6 = nth_idx(OP_RAM_READ, 204);
        chk("t3_addr_1020", (i6 < 0) ? -1 : strobe_log[i6].cmd, 1020);
        i6 = nth_idx(OP_RAM_READ, 205);
        chk("t3_addr_wrap", (i6 < 0) ? -1 : strobe_log[i6].cmd, 1);
        bus.fifo_empty = '1;

        // one data packet, then all empty: heartbeats reuse the unchanged address
        do_reset(only_set(9, 0, 0), 1'b1);
        wait_strobe(1, 10, "t4_first_read");
        bus.fifo_empty = '1;
        wait_tx(3, SEQ + 2 * (HB + PW + 5), "t4_tx_seen");
        chk("t4_fifo_reads", count_op(OP_FIFO_READ), 1);
        i6 = nth_idx(OP_RAM_READ, 1);
        chk("t4_hb1_addr", (i6 < 0) ? -1 : strobe_log[i6].cmd, WORDS);
        chk("t4_hb1_gap", (i6 < 0) ? -1 : strobe_log[i6].cyc - tx_log[0].cyc, PW + HB + 1);
        chk("t4_hb1_tx", tx_log[1].cyc - ((i6 < 0) ? 0 : strobe_log[i6].cyc), 1);
        i6 = nth_idx(OP_RAM_READ, 2);
        chk("t4_hb2_addr", (i6 < 0) ? -1 : strobe_log[i6].cmd, WORDS);
        chk("t4_hb2_gap", (i6 < 0) ? -1 : strobe_log[i6].cyc - tx_log[1].cyc, PW + HB + 1);
        chk("t4_seq", tx_log[2].seq, 3);

        // enable dropped during FIFO_HOLD: sequence completes, nothing follows
        do_reset(only_set(7, 11, 0), 1'b1);
        wait_strobe(1, 10, "t5_first_read");
        repeat (5) step();
        chk("t5_state_hold", bus.state, ST_FIFO_HOLD);
        bus.enable = 1'b0;
        wait_tx(1, SEQ + 10, "t5_tx_seen");
        repeat (2 * (SEQ + HB)) step();
        chk("t5_strobes", strobe_log.size(), 2);
        chk("t5_packets", tx_log.size(), 1);
        chk("t5_idle", bus.busy, 0);

        // asynchronous reset in the middle of PKT_HOLD
        do_reset(only_set(4, 0, 0), 1'b1);
        wait_tx(1, SEQ + 10, "t6_tx_seen");
        repeat (5) step();
        chk("t6_in_pkt_hold", bus.state, ST_PKT_HOLD);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_state", bus.state, ST_IDLE);
        chk("t6_busy", bus.busy, 0);
        chk("t6_tx_strobe", bus.tx_strobe, 0);
        chk("t6_seqnum", bus.seqnum, 0);
        chk("t6_cmd_op", {bus.strobe, bus.opcode, bus.command}, 0);

        // randomized traffic and enable toggling against the model
        do_reset('1, 1'b1);
        for (int t = 0; t < 5000; t++) begin
            step();
            if ($urandom_range(0, 15) == 0) begin
                fe = '1;
                for (int k = 1; k <= B; k++) if ($urandom_range(0, 7) == 0) fe[k] = 1'b0;
                if ($urandom_range(0, 2) == 0) fe = '1;
                bus.fifo_empty = fe;
            end
            if ($urandom_range(0, 39) == 0) bus.enable = ~bus.enable;
        end
        bus.enable = 1'b0;
        repeat (SEQ + 10) step();
        chk("pending_events", exp_q.size(), 0);
        chk("final_idle", bus.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
